// File: rtl/bram_frame_ctrl.sv
// Frame-buffer BRAM sequencer: turns the camera pixel stream into BRAM writes and turns display
// requests into BRAM reads. The optional short-frame detector is built only when FRAME_ERR_EN
// is defined.
module bram_frame_ctrl #(
    parameter int unsigned H_RES  = 640,
    parameter int unsigned V_RES  = 480,
    parameter int unsigned ADDR_W = 19
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cmos_vsync_i,
    input  logic              cmos_pixel_valid_i,
    input  logic              capture_req_i,
    input  logic              continuous_i,
    input  logic              rd_frame_start_i,
    input  logic              rd_req_i,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic              rd_en_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic              busy_o,
    output logic              frame_done_o,
    output logic              short_frame_o
);

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(H_RES * V_RES - 1);

    typedef enum logic [1:0] {StIdle, StArmed, StCapture} state_e;

    state_e            state_q, state_d;
    logic              vsync_q;
    logic              vsync_rise;
    logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic              frame_done_q, frame_done_d;
    logic              busy_q, busy_d;
    logic [ADDR_W-1:0] rd_cnt_q, rd_cnt_d;
    logic              rd_en_q, rd_en_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              last_write;

    // Registered vsync resets low, so a vsync already high at reset release is not an edge.
    assign vsync_rise = cmos_vsync_i & ~vsync_q;

    // Final pixel of the frame is being accepted this cycle.
    assign last_write = (state_q == StCapture) && !vsync_rise && cmos_pixel_valid_i &&
                        (wr_cnt_q == LastAddr);

    // Write FSM state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Write FSM next-state logic; capture_req outside IDLE has no effect on sequencing.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (capture_req_i || continuous_i) state_d = StArmed;
            StArmed:   if (vsync_rise) state_d = StCapture;
            StCapture: if (last_write) state_d = continuous_i ? StArmed : StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Write datapath and registered-output next values. A vsync edge during capture restarts the
    // frame and the pixel strobe of that same cycle is dropped.
    always_comb begin
        wr_cnt_d     = wr_cnt_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        frame_done_d = 1'b0;
        if ((state_q == StArmed || state_q == StCapture) && vsync_rise) begin
            wr_cnt_d = '0;
        end else if (state_q == StCapture && cmos_pixel_valid_i) begin
            wr_en_d      = 1'b1;
            wr_addr_d    = wr_cnt_q;
            wr_cnt_d     = wr_cnt_q + 1'b1;
            frame_done_d = last_write;
        end
        // Busy stays up through the frame_done cycle and drops one cycle later.
        busy_d = (state_d != StIdle) || frame_done_d;
    end

    // Read counter: frame start rewinds, a simultaneous request reads address 0.
    always_comb begin
        rd_cnt_d  = rd_cnt_q;
        rd_en_d   = rd_req_i;
        rd_addr_d = rd_addr_q;
        if (rd_req_i) begin
            rd_addr_d = rd_frame_start_i ? '0 : rd_cnt_q;
            rd_cnt_d  = (rd_addr_d == LastAddr) ? '0 : rd_addr_d + 1'b1;
        end else if (rd_frame_start_i) begin
            rd_cnt_d = '0;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vsync_q      <= 1'b0;
            wr_cnt_q     <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
            rd_cnt_q     <= '0;
            rd_en_q      <= 1'b0;
            rd_addr_q    <= '0;
        end else begin
            vsync_q      <= cmos_vsync_i;
            wr_cnt_q     <= wr_cnt_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
            rd_cnt_q     <= rd_cnt_d;
            rd_en_q      <= rd_en_d;
            rd_addr_q    <= rd_addr_d;
        end
    end

    assign wr_en_o      = wr_en_q;
    assign wr_addr_o    = wr_addr_q;
    assign rd_en_o      = rd_en_q;
    assign rd_addr_o    = rd_addr_q;
    assign busy_o       = busy_q;
    assign frame_done_o = frame_done_q;

`ifdef FRAME_ERR_EN
    logic short_q, short_d;

    // Sticky short-frame flag: set by a restart with pixels already written, cleared by a request.
    always_comb begin
        short_d = short_q;
        if (capture_req_i) short_d = 1'b0;
        if (state_q == StCapture && vsync_rise && wr_cnt_q != '0) short_d = 1'b1;
    end

    // Short-frame flag register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            short_q <= 1'b0;
        end else begin
            short_q <= short_d;
        end
    end

    assign short_frame_o = short_q;
`else
    assign short_frame_o = 1'b0;
`endif

endmodule

// File: tb/tb_bram_frame_ctrl.sv
// Bench for bram_frame_ctrl with a 4x2 frame. A frame-level reference model predicts every
// registered output each cycle; directed segments pin the observed address streams to literals.
module tb_bram_frame_ctrl;

    localparam int unsigned HR    = 4;
    localparam int unsigned VR    = 2;
    localparam int unsigned AW    = 3;
    localparam int unsigned FRAME = HR * VR;
`ifdef FRAME_ERR_EN
    localparam bit ErrEn = 1'b1;
`else
    localparam bit ErrEn = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          vs = 1'b0, pv = 1'b0, cr = 1'b0, ct = 1'b0, fs = 1'b0, rq = 1'b0;
    logic          wr_en, rd_en, busy, frame_done, short_frame;
    logic [AW-1:0] wr_addr, rd_addr;

    int total = 0;
    int bad   = 0;

    bram_frame_ctrl #(.H_RES(HR), .V_RES(VR), .ADDR_W(AW)) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .cmos_vsync_i       (vs),
        .cmos_pixel_valid_i (pv),
        .capture_req_i      (cr),
        .continuous_i       (ct),
        .rd_frame_start_i   (fs),
        .rd_req_i           (rq),
        .wr_en_o            (wr_en),
        .wr_addr_o          (wr_addr),
        .rd_en_o            (rd_en),
        .rd_addr_o          (rd_addr),
        .busy_o             (busy),
        .frame_done_o       (frame_done),
        .short_frame_o      (short_frame)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d expected=%0d at %0t", name, got, exp, $time);
        end
    endtask

    // Frame-level reference: waiting for a frame, filling it pixel by pixel, or doing nothing.
    bit waiting = 0, filling = 0, prev_vs = 0;
    int pix = 0, rpix = 0;
    bit e_wr_en = 0, e_rd_en = 0, e_done = 0, e_short = 0;
    int e_wr_addr = 0, e_rd_addr = 0;

    always @(posedge clk) begin
        if (rst) begin
            waiting = 0; filling = 0; prev_vs = 0; pix = 0; rpix = 0;
            e_wr_en = 0; e_rd_en = 0; e_done = 0; e_short = 0; e_wr_addr = 0; e_rd_addr = 0;
        end else begin
            bit rise;
            rise    = vs && !prev_vs;
            prev_vs = vs;
            e_wr_en = 0;
            e_done  = 0;
            if (cr) e_short = 0;
            if (filling) begin
                if (rise) begin
                    if (pix != 0 && ErrEn) e_short = 1;
                    pix = 0;
                end else if (pv) begin
                    e_wr_en   = 1;
                    e_wr_addr = pix;
                    pix++;
                    if (pix == FRAME) begin
                        e_done  = 1;
                        filling = 0;
                        waiting = ct;
                    end
                end
            end else if (waiting) begin
                if (rise) begin
                    waiting = 0;
                    filling = 1;
                    pix     = 0;
                end
            end else if (cr || ct) begin
                waiting = 1;
            end
            e_rd_en = rq;
            if (rq) begin
                e_rd_addr = fs ? 0 : rpix;
                rpix      = (e_rd_addr + 1) % FRAME;
            end else if (fs) begin
                rpix = 0;
            end
        end
    end

    int wr_log[$];
    int rd_log[$];
    int done_cnt = 0;

    // Per-cycle comparison against the model, plus logging of observed transactions.
    always @(posedge clk) begin
        #3;
        check("wr_en", wr_en, e_wr_en);
        check("wr_addr", wr_addr, e_wr_addr);
        check("rd_en", rd_en, e_rd_en);
        check("rd_addr", rd_addr, e_rd_addr);
        check("busy", busy, (waiting || filling || e_done) ? 1 : 0);
        check("frame_done", frame_done, e_done);
        check("short_frame", short_frame, e_short);
        if (wr_en) wr_log.push_back(int'(wr_addr));
        if (rd_en) rd_log.push_back(int'(rd_addr));
        if (frame_done) done_cnt++;
    end

    task automatic drive(input bit i_vs, i_pv, i_cr, i_ct, i_fs, i_rq);
        vs = i_vs; pv = i_pv; cr = i_cr; ct = i_ct; fs = i_fs; rq = i_rq;
        @(negedge clk);
    endtask

    task automatic clear_logs();
        wr_log.delete();
        rd_log.delete();
        done_cnt = 0;
    endtask

    int busy_low;

    initial begin
        repeat (2) @(negedge clk);
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_busy", busy, 0);
        check("rst_short", short_frame, 0);
        rst = 1'b0;

        // Single shot: arm, vsync edge, 8 pixels, then a stray 9th pixel.
        drive(0, 0, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        check("ss_busy_armed", busy, 1);
        drive(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) drive(0, 1, 0, 0, 0, 0);
        check("ss_done_pulse", frame_done, 1);
        check("ss_busy_at_done", busy, 1);
        drive(0, 0, 0, 0, 0, 0);
        check("ss_busy_after", busy, 0);
        drive(0, 1, 0, 0, 0, 0);
        check("ss_9th_no_write", wr_en, 0);
        check("ss_count", wr_log.size(), 8);
        for (int i = 0; i < wr_log.size(); i++) check("ss_addr", wr_log[i], i);
        check("ss_done_cnt", done_cnt, 1);

        // Gapped valid pattern 1,0,1,1.
        clear_logs();
        drive(0, 0, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        check("gap_no_write", wr_en, 0);
        drive(0, 1, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0);
        check("gap_count", wr_log.size(), 3);
        for (int i = 0; i < wr_log.size(); i++) check("gap_addr", wr_log[i], i);

        // Restart after 3 pixels, then finish the restarted frame.
        clear_logs();
        drive(1, 0, 0, 0, 0, 0);
        check("short_set", short_frame, ErrEn);
        drive(0, 1, 0, 0, 0, 0);
        check("short_restart_addr", wr_addr, 0);
        drive(0, 0, 1, 0, 0, 0);
        check("short_cleared", short_frame, 0);
        for (int i = 0; i < 7; i++) drive(0, 1, 0, 0, 0, 0);
        check("short_done_cnt", done_cnt, 1);
        check("short_last_addr", wr_log[wr_log.size()-1], 7);

        // Continuous: two full frames, then drop continuous mid third frame.
        clear_logs();
        busy_low = 0;
        drive(0, 0, 0, 1, 0, 0);
        for (int f = 0; f < 2; f++) begin
            drive(1, 0, 0, 1, 0, 0);
            if (!busy) busy_low++;
            for (int i = 0; i < 8; i++) begin
                drive(0, 1, 0, 1, 0, 0);
                if (!busy) busy_low++;
            end
        end
        check("cont_busy_held", busy_low, 0);
        check("cont_done_cnt", done_cnt, 2);
        check("cont_count", wr_log.size(), 16);
        check("cont_frame2_start", wr_log[8], 0);
        drive(1, 0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) drive(0, 1, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) drive(0, 1, 0, 0, 0, 0);
        check("drop_done_cnt", done_cnt, 3);
        drive(0, 0, 0, 0, 0, 0);
        check("drop_idle", busy, 0);

        // Read side: wrap, then rewind together with a request.
        clear_logs();
        for (int i = 0; i < 11; i++) drive(0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 1, 1);
        drive(0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0);
        check("rd_count", rd_log.size(), 13);
        for (int i = 0; i < 8; i++) check("rd_addr_seq", rd_log[i], i);
        check("rd_wrap", rd_log[8], 0);
        check("rd_pre_rewind", rd_log[10], 2);
        check("rd_rewind", rd_log[11], 0);
        check("rd_after_rewind", rd_log[12], 1);

        // Reset in the middle of a capture.
        drive(0, 0, 1, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) drive(0, 1, 0, 0, 0, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_wr_en", wr_en, 0);
        check("mid_rst_wr_addr", wr_addr, 0);
        check("mid_rst_rd_en", rd_en, 0);
        check("mid_rst_rd_addr", rd_addr, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", frame_done, 0);
        check("mid_rst_short", short_frame, 0);
        @(negedge clk);
        drive(0, 1, 0, 0, 0, 0);
        rst = 1'b0;
        clear_logs();
        drive(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) drive(0, 1, 0, 0, 0, 0);
        check("post_rst_no_writes", wr_log.size(), 0);
        check("post_rst_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bram_frame_ctrl.md
# bram_frame_ctrl

Single-clock sequencer for the 640x480 frame-buffer BRAM. It turns the camera pixel stream (vsync and valid strobes) into BRAM write-enable/address pairs, and display pixel requests into read-enable/address pairs. It supports single-shot and continuous frame capture, frame-complete signalling and short-frame error detection. It sits between the CMOS capture front end, the VGA timing generator and the frame-buffer BRAM.

## Interface
- `H_RES`, default 640: pixels per line.
- `V_RES`, default 480: lines per frame.
- `ADDR_W`, default 19: address width; must satisfy 2^ADDR_W >= H_RES*V_RES.
- `clk` in 1: single clock. All camera and display strobes are already synchronous to it.
- `rst` in 1: asynchronous, active-high reset.
- `cmos_vsync` in 1: camera frame sync; its rising edge marks a frame start.
- `cmos_pixel_valid` in 1: one camera pixel present this cycle.
- `capture_req` in 1: one-cycle pulse that arms a single-frame capture.
- `continuous` in 1: level; while 1, capture every frame.
- `rd_frame_start` in 1: display frame-start pulse; rewinds the read address.
- `rd_req` in 1: display needs one pixel this cycle.
- `wr_en` out 1: BRAM write enable; also drives the BRAM pixel-valid input.
- `wr_addr` out ADDR_W: BRAM write address.
- `rd_en` out 1: BRAM read enable.
- `rd_addr` out ADDR_W: BRAM read address.
- `busy` out 1: high in states ARMED and CAPTURE.
- `frame_done` out 1: one-cycle pulse when the last pixel of a frame has been written.
- `short_frame` out 1: sticky error flag (see Configuration).

## Operation
- Write FSM states: IDLE, ARMED, CAPTURE.
  - IDLE -> ARMED when `capture_req`=1 or `continuous`=1.
  - ARMED -> CAPTURE on a `cmos_vsync` rising edge. The write counter is cleared to 0.
  - In CAPTURE, each cycle with `cmos_pixel_valid`=1 produces `wr_en`=1 and `wr_addr`=counter, then the counter increments.
  - Pixels without valid produce `wr_en`=0. The BRAM is never written with invalid data.
- When the write of address H_RES*V_RES-1 is issued:
  - `frame_done` pulses on that same output cycle.
  - The FSM goes to ARMED if `continuous`=1, otherwise to IDLE.
  - Any further valid pixels before the next armed vsync are ignored.
- Vsync rising edge while in CAPTURE (frame ended early): the counter is cleared to 0 and the FSM stays in CAPTURE. The new frame is captured.
- Vsync edge detection uses a registered copy of `cmos_vsync`, which resets to 0. A vsync already high at reset release is therefore not an edge.
- `capture_req` in ARMED or CAPTURE is ignored; it does not queue a second capture.
- Dropping `continuous` mid-frame finishes the current frame, then the FSM goes to IDLE.
- Read side runs independently of the write FSM:
  - `rd_frame_start` clears the read counter.
  - Each `rd_req` cycle produces `rd_en`=1 and `rd_addr`=counter, then the counter increments.
  - The counter wraps from H_RES*V_RES-1 to 0.
  - If `rd_frame_start` and `rd_req` are asserted together, the read uses address 0 and the counter becomes 1.
- Reads and writes may target the same address in the same cycle. The BRAM is dual-port, so no arbitration is needed; the read returns the old or new value, and either is acceptable.

## Timing
- All outputs are registered.
- Reset values: `wr_en`=0, `wr_addr`=0, `rd_en`=0, `rd_addr`=0, `busy`=0, `frame_done`=0, `short_frame`=0. FSM resets to IDLE, both counters to 0.
- `wr_en`/`wr_addr` appear one cycle after the `cmos_pixel_valid` sample. The front end delays pixel data by one register to match.
- Vsync rising edge at cycle n: a valid pixel at n+1 is written to address 0.
- `rd_en`/`rd_addr` appear one cycle after `rd_req`. BRAM data is available two cycles after `rd_req`.
- `busy` rises the cycle after the arming event and falls the cycle after `frame_done` when not continuous.
- Reset asserted mid-frame: all outputs go to their reset values immediately (asynchronous), and no partial write is issued.

## Configuration
- `FRAME_ERR_EN` defined:
  - `short_frame` sets when a vsync rising edge arrives in CAPTURE with the counter nonzero.
  - It clears only on `rst` or `capture_req`.
- `FRAME_ERR_EN` undefined:
  - `short_frame` is tied to 0 and no detection logic is built.
  - The restart-on-vsync behaviour is unchanged.

## Test plan
- Single shot, H_RES=4 and V_RES=2 override: `capture_req`, vsync edge, then 8 valid pixels -> `wr_addr` 0..7 with `wr_en`=1, `frame_done` pulse with address 7, FSM returns to IDLE. A 9th valid pixel gives `wr_en`=0.
- Gapped valid: valid pattern 1,0,1,1 after vsync -> writes to addresses 0, 1, 2 only, with no `wr_en` in the gap cycle.
- Continuous mode, two frames -> two `frame_done` pulses and `busy` held high throughout. Each frame starts at address 0.
- Short frame, `FRAME_ERR_EN` defined: vsync edge after 3 pixels -> `short_frame`=1 and the next valid pixel writes address 0. `capture_req` clears the flag.
- Read wrap: 9 `rd_req` cycles with 4x2 geometry -> `rd_addr` 0..7, then 0. `rd_frame_start` together with `rd_req` mid-stream -> address 0, then 1.
- Reset mid-capture after 5 pixels -> all outputs 0 during reset. After release, vsync with no arming produces no writes.
